// File: rtl/huffman_pkg.sv
// Shared types for the Huffman bit packer: FIFO entry layout and packer FSM states.
package huffman_pkg;

  localparam int PACK_WORD_W = 8;
  localparam int PAD_W       = $clog2(PACK_WORD_W);

  typedef struct packed {
    logic                   last;
    logic [PAD_W-1:0]       pad;
    logic [PACK_WORD_W-1:0] word;
  } pack_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } pack_state_t;

endpackage

// File: rtl/huffman_pack_fifo.sv
// First-word fall-through FIFO of packed words; a push into a full FIFO is only
// taken when a pop frees the head slot in the same cycle.
module huffman_pack_fifo
  import huffman_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pack_entry_t            entry_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output pack_entry_t            head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  pack_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= entry_i;
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the encoder's serial code bits MSB-first into words, queues them in a
// small FIFO and tracks message length, completion and dropped data.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int WORD_W     = PACK_WORD_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bit_valid_i,
  input  logic                      bit_i,
  input  logic                      last_i,
  output logic                      word_valid_o,
  output logic [WORD_W-1:0]         word_o,
  output logic                      word_last_o,
  output logic [$clog2(WORD_W)-1:0] pad_o,
  input  logic                      word_ready_i,
  output logic [CNT_W-1:0]          total_bit_o,
  output logic                      done_o,
  output logic                      overflow_o
);

  localparam logic [PAD_W-1:0] LAST_POS = PAD_W'(WORD_W - 1);
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;

  pack_state_t       state_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] next_word;
  logic [PAD_W-1:0]  fill_q;
  logic [PAD_W-1:0]  bit_pos;
  logic              accept;
  logic              push;
  logic              pop;
  logic              drop_bit;
  logic              drop_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  pack_entry_t       push_entry;
  pack_entry_t       head;

  assign accept    = bit_valid_i && (state_q == IDLE || state_q == RUN);
  assign push      = accept && (last_i || fill_q == LAST_POS);
  assign pop       = !fifo_empty && word_ready_i;
  assign drop_bit  = bit_valid_i && (state_q == DRAIN || state_q == DONE);
  assign drop_word = push && fifo_full && !pop;
  assign bit_pos   = LAST_POS - fill_q;

  // The incoming bit lands at the next free MSB-side position; bits not yet
  // received stay zero, which is exactly the pad of a final partial word.
  always_comb begin
    next_word          = shift_q;
    next_word[bit_pos] = bit_i;
    push_entry.word    = next_word;
    push_entry.last    = last_i;
    push_entry.pad     = last_i ? bit_pos : '0;
  end

  huffman_pack_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i (push_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  assign word_valid_o = !fifo_empty;
  assign word_o       = fifo_empty ? '0 : head.word;
  assign word_last_o  = !fifo_empty && head.last;
  assign pad_o        = fifo_empty ? '0 : head.pad;

  // DRAIN looks one pop ahead so done_o rises the cycle after the final pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      fill_q      <= '0;
      total_bit_o <= '0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (drop_bit || drop_word) overflow_o <= 1'b1;

      if (accept) begin
        if (push) begin
          shift_q <= '0;
          fill_q  <= '0;
        end else begin
          shift_q <= next_word;
          fill_q  <= fill_q + 1'b1;
        end
        if (state_q == IDLE)        total_bit_o <= CNT_W'(1);
        else if (total_bit_o != '1) total_bit_o <= total_bit_o + 1'b1;
      end

      case (state_q)
        IDLE, RUN: begin
          if (accept) state_q <= last_i ? DRAIN : RUN;
        end
        DRAIN: begin
          if (fifo_empty || (pop && fifo_count == CW'(1))) begin
            state_q <= DONE;
            done_o  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_huffman_bit_packer;

  localparam int DEPTH   = 4;
  localparam int MAX_CNT = 2047;

  typedef struct {
    logic [7:0] word;
    logic       last;
    logic [2:0] pad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_valid = 1'b0;
  logic        code_bit = 1'b0;
  logic        last_bit = 1'b0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [7:0]  word;
  logic        word_last;
  logic [2:0]  pad;
  logic [10:0] total_bits;
  logic        done;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t mq[$];
  logic pend[$];
  int   total_m = 0;
  bit   ovf_m = 0;
  bit   draining_m = 0;
  bit   done_m = 0;
  bit   msg_open_m = 0;
  bit   model_on = 0;

  exp_t popped[$];
  int   done_count = 0;

  huffman_bit_packer #(
    .WORD_W     (8),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (11)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_valid_i  (bit_valid),
    .bit_i        (code_bit),
    .last_i       (last_bit),
    .word_valid_o (word_valid),
    .word_o       (word),
    .word_last_o  (word_last),
    .pad_o        (pad),
    .word_ready_i (word_ready),
    .total_bit_o  (total_bits),
    .done_o       (done),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Reference model: messages as bit lists, the FIFO as a bounded queue of words.
  always @(posedge clk) begin : model_update
    bit   popping;
    bit   was_draining;
    bit   was_done;
    exp_t e;
    if (rst) begin
      mq.delete();
      pend.delete();
      total_m    = 0;
      ovf_m      = 0;
      draining_m = 0;
      done_m     = 0;
      msg_open_m = 0;
      model_on   = 1;
    end else if (model_on) begin
      popping      = (mq.size() > 0) && word_ready;
      was_draining = draining_m;
      was_done     = done_m;
      if (popping) void'(mq.pop_front());
      done_m = 0;
      if (bit_valid) begin
        if (was_draining || was_done) begin
          ovf_m = 1;
        end else begin
          if (!msg_open_m) begin
            total_m    = 1;
            msg_open_m = 1;
          end else if (total_m < MAX_CNT) begin
            total_m = total_m + 1;
          end
          pend.push_back(code_bit);
          if (pend.size() == 8 || last_bit) begin
            e.word = 8'h00;
            for (int i = 0; i < pend.size(); i++) e.word[7-i] = pend[i];
            e.last = last_bit;
            e.pad  = last_bit ? 3'(8 - pend.size()) : 3'd0;
            if (mq.size() < DEPTH) mq.push_back(e);
            else ovf_m = 1;
            pend.delete();
            if (last_bit) begin
              draining_m = 1;
              msg_open_m = 0;
            end
          end
        end
      end
      if (was_draining && mq.size() == 0) begin
        draining_m = 0;
        done_m     = 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    exp_t got;
    if (model_on) begin
      checkOutput("word_valid", int'(word_valid), int'(mq.size() > 0));
      if (mq.size() > 0 && word_valid) begin
        checkOutput("word", int'(word), int'(mq[0].word));
        checkOutput("word_last", int'(word_last), int'(mq[0].last));
        checkOutput("pad", int'(pad), int'(mq[0].pad));
      end
      checkOutput("total_bits", int'(total_bits), total_m);
      checkOutput("done", int'(done), int'(done_m));
      checkOutput("overflow", int'(overflow), int'(ovf_m));
      if (word_valid && word_ready) begin
        got.word = word;
        got.last = word_last;
        got.pad  = pad;
        popped.push_back(got);
      end
      if (done) done_count++;
    end
  end

  task automatic applyStimulus(input logic v, input logic b, input logic l, input logic r);
    bit_valid  = v;
    code_bit   = b;
    last_bit   = l;
    word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input int cycles);
    rst       = 1'b1;
    bit_valid = 1'b0;
    last_bit  = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] val, input logic last_at_end, input logic r);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, val[7-i], last_at_end && (i == 7), r);
  endtask

  task automatic waitDone(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("done_pulses", done_count - start, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_word_valid", int'(word_valid), 0);
    checkOutput("rst_word", int'(word), 0);
    checkOutput("rst_word_last", int'(word_last), 0);
    checkOutput("rst_pad", int'(pad), 0);
    checkOutput("rst_total", int'(total_bits), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetDut(2);
    checkResetState();

    // Two full words of alternating bits.
    popped.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i % 2 == 0), (i == 15), 1'b1);
    waitDone(20);
    checkOutput("alt_count", popped.size(), 2);
    if (popped.size() == 2) begin
      checkOutput("alt_w0", int'(popped[0].word), 'hAA);
      checkOutput("alt_w1", int'(popped[1].word), 'hAA);
      checkOutput("alt_last", int'(popped[1].last), 1);
      checkOutput("alt_pad", int'(popped[1].pad), 0);
    end
    checkOutput("alt_total", int'(total_bits), 16);

    // Short partial word.
    popped.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitDone(20);
    checkOutput("short_count", popped.size(), 1);
    if (popped.size() == 1) begin
      checkOutput("short_word", int'(popped[0].word), 'hC0);
      checkOutput("short_pad", int'(popped[0].pad), 5);
      checkOutput("short_last", int'(popped[0].last), 1);
    end
    checkOutput("short_total", int'(total_bits), 3);

    // Consumer stalled: fifth word (the last-tagged one) is dropped.
    popped.delete();
    for (int k = 1; k <= 5; k++) sendByte(8'(k), k == 5, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_overflow", int'(overflow), 1);
    checkOutput("stall_held", int'(word_valid), 1);
    waitDone(20);
    checkOutput("stall_count", popped.size(), 4);
    for (int k = 0; k < popped.size() && k < 4; k++) begin
      checkOutput("stall_word", int'(popped[k].word), k + 1);
      checkOutput("stall_last", int'(popped[k].last), 0);
    end

    // Full FIFO with simultaneous pop and push.
    resetDut(1);
    popped.delete();
    for (int k = 1; k <= 4; k++) sendByte(8'(k * 'h11), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h55;
      applyStimulus(1'b1, v[7-i], i == 7, i == 7);
    end
    waitDone(20);
    checkOutput("simul_overflow", int'(overflow), 0);
    checkOutput("simul_count", popped.size(), 5);
    for (int k = 0; k < popped.size() && k < 5; k++)
      checkOutput("simul_word", int'(popped[k].word), (k + 1) * 'h11);
    if (popped.size() == 5) checkOutput("simul_last", int'(popped[4].last), 1);

    // Reset mid-message.
    resetDut(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    resetDut(1);
    checkResetState();
    popped.delete();
    sendByte(8'hFF, 1'b1, 1'b1);
    waitDone(20);
    checkOutput("post_rst_count", popped.size(), 1);
    if (popped.size() == 1) checkOutput("post_rst_word", int'(popped[0].word), 'hFF);
    checkOutput("post_rst_total", int'(total_bits), 8);

    // Bits during DRAIN are dropped.
    resetDut(1);
    popped.delete();
    sendByte(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_overflow", int'(overflow), 1);
    checkOutput("drain_total", int'(total_bits), 8);
    waitDone(20);
    if (popped.size() == 1) checkOutput("drain_word", int'(popped[0].word), 'h5A);
    else checkOutput("drain_count", popped.size(), 1);

    // Bit counter saturation.
    resetDut(1);
    for (int i = 0; i < 2100; i++) applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1);
    checkOutput("sat_total", int'(total_bits), MAX_CNT);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    waitDone(20);
    checkOutput("sat_total_after", int'(total_bits), MAX_CNT);

    // Randomized traffic against the model.
    resetDut(1);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(9) < 7), 1'($urandom_range(1)),
                    1'($urandom_range(15) == 0), 1'($urandom_range(9) < 6));
    end
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream stage of the Huffman encoder. It consumes the encoder's serial code-bit stream, one bit per cycle with no backpressure, and packs the bits MSB-first into WORD_W-bit words. Words are buffered in a small FIFO and released over a valid/ready interface, with a last-word tag and a pad count. It also reports the total encoded bit count and flags dropped bits.

## Interface
- WORD_W, 8, packed word width
- FIFO_DEPTH, 4, word FIFO entries (power of two, ≥2)
- CNT_W, 11, width of total bit counter

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- bit_valid_i  in  1  bit_i carries a code bit this cycle
- bit_i  in  1  code bit
- last_i  in  1  final bit of message; meaningful only with bit_valid_i=1
- word_valid_o  out  1  FIFO head valid
- word_o  out  WORD_W  packed word, first-received bit in MSB
- word_last_o  out  1  head is final word of message
- pad_o  out  $clog2(WORD_W)  zero pad bits in LSBs of head word (0..WORD_W-1)
- word_ready_i  in  1  consumer accepts head when word_valid_o=1
- total_bit_o  out  CNT_W  accepted bits of current/last message, saturating
- done_o  out  1  one-cycle pulse: final word has been popped
- overflow_o  out  1  sticky: at least one bit or word dropped since reset

## Operation
- Reset values: every output 0; FIFO empty; fill=0; state IDLE.
- FSM:
  - IDLE: first accepted bit clears total_bit_o to 1 and goes to RUN.
  - RUN: bits are accepted. A bit with last_i=1 moves the FSM to DRAIN.
  - DRAIN: waits for the FIFO to empty (the last-tagged word popped), then goes to DONE.
  - DONE: done_o=1 for this cycle, then IDLE.
- Accepting a bit: the bit is shifted into the shift register at position WORD_W-1-fill, and fill increments. total_bit_o increments and saturates at 2^CNT_W-1.
- Push: a word is pushed when the bit completes the word (fill reaches WORD_W), or when the bit has last_i=1. On push:
  - unfilled LSBs are 0;
  - pad = WORD_W-(fill+1) for the last partial word, otherwise 0;
  - last tag = last_i;
  - fill returns to 0.
- last_i with bit_valid_i=0 is ignored.
- Bits arriving in DRAIN or DONE are dropped and set overflow_o. They do not count in total_bit_o.
- FIFO:
  - Entries are {last, pad, word}. The head is presented combinationally from storage (first-word fall-through).
  - Pop occurs when word_valid_o & word_ready_i.
  - Push when full is allowed only if a pop happens in the same cycle. Otherwise the word is dropped, overflow_o is set, fill is still cleared, and the FSM still follows last_i.
  - If a last-tagged word is dropped, DRAIN ends when the FIFO empties.
- overflow_o clears only on rst_i.
- Pointers wrap modulo FIFO_DEPTH. A count register distinguishes full from empty.

## Timing
- Bit accepted at cycle N completing a word (or carrying last_i) → word_valid_o=1 at N+1 if the FIFO was empty.
- Throughput: one bit per cycle sustained. The FIFO absorbs FIFO_DEPTH words of consumer stall.
- Last word popped at cycle M → done_o=1 at M+1, state IDLE at M+2. A new message can start at M+2; bits at M+1 are dropped.
- word_o, word_last_o and pad_o are stable while word_valid_o=1 and word_ready_i=0.
- rst_i mid-message discards the partial word and FIFO contents. All outputs are 0 the following cycle.

## Structure
- Package huffman_pkg: the pack_entry_t struct {logic last; logic [PAD_W-1:0] pad; logic [WORD_W-1:0] word}, PAD_W, the FSM enum pack_state_t {IDLE, RUN, DRAIN, DONE}.
- Sub-module huffman_pack_fifo: parameterized synchronous FIFO of pack_entry_t with push, pop, full, empty and the head entry.
- Top holds the FSM, shift register, fill counter, bit counter and overflow flag.

## Test plan
- 16 bits of alternating 1,0 with last_i on bit 16 and ready=1 → words 0xAA, 0xAA. The second word has word_last_o=1, pad_o=0. total_bit_o=16, and done_o pulses once, one cycle after that pop.
- Bits 1,1,0 with last_i on the third bit → word 0xC0, pad_o=5, word_last_o=1, total_bit_o=3.
- ready=0, 40 bits with last on bit 40 → 4 words held, overflow_o=1, 5th word dropped. Raise ready → 4 words in order, then done_o.
- FIFO full with pop and push in the same cycle → no drop, overflow_o stays 0, word order preserved.
- 4 bits, then rst_i for 1 cycle, then 8 bits of 1 → all outputs 0 after reset. Next word is 0xFF with total_bit_o=8.
- Bits during DRAIN (ready=0 after last) → bits dropped, overflow_o=1, total_bit_o unchanged.
